prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 147 ++++++++++++++
 tb/tb_prefetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Byte-granular instruction prefetch queue. The bus unit pushes 32-bit
// little-endian fetch words (4 bytes at a time). The decoder sees a 4-byte
// window of the oldest queued bytes and retires 1..4 bytes per cycle.
// A flush (control transfer) empties the queue in one cycle.
//
// Optional feature macro: PREFETCH_QUEUE_CHECK_EN
//   defined   : over-consumes and fetches offered while not ready are ignored
//               and raise the sticky o_error flag.
//   undefined : o_error is tied low, an over-consume is clamped to the
//               current occupancy, and a fetch offered while not ready is
//               dropped silently.
//
// Parameters
//   DEPTH              queue capacity in bytes (power of two, 8..64)
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_reset_n          asynchronous active-low reset
//   i_fetch_valid      a fetch word is offered this cycle
//   i_fetch_data       fetch word, bits [7:0] are the lowest-addressed byte
//   o_fetch_ready      queue can accept one fetch word this cycle
//   o_instruction      window of the oldest 4 bytes, index 0 is the oldest;
//                      slots beyond the occupancy read as 8'h00
//   o_bytes_available  current occupancy in bytes
//   i_consume_valid    decoder retires bytes this cycle
//   i_consume_count    number of bytes retired (1..4; 0 is a no-op)
//   i_flush            discard all queued bytes
//   o_error            sticky protocol-violation flag
// -----------------------------------------------------------------------------
module prefetch_queue #(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_fetch_valid,
   input  logic [31:0]              i_fetch_data,
   output logic                     o_fetch_ready,
   output logic [0:3][7:0]          o_instruction,
   output logic [$clog2(DEPTH):0]   o_bytes_available,
   input  logic                     i_consume_valid,
   input  logic [2:0]               i_consume_count,
   input  logic                     i_flush,
   output logic                     o_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Byte storage; contents are never reset, only the pointers/occupancy.
   logic [7:0]    mem [DEPTH];

   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic [CW-1:0] cnt_ext;
   logic [CW-1:0] consume_amt;
   logic          over_consume;
   logic          fetch_accept;

   // Ready depends only on registered occupancy, never on a same-cycle consume.
   assign o_fetch_ready     = (count_reg <= CW'(DEPTH - 4));
   assign o_bytes_available = count_reg;

   always_comb begin
      cnt_ext      = CW'(i_consume_count);
      over_consume = i_consume_valid && (cnt_ext > count_reg);
      fetch_accept = i_fetch_valid && o_fetch_ready;

`ifdef PREFETCH_QUEUE_CHECK_EN
      // An over-consume is rejected outright.
      consume_amt  = (i_consume_valid && !over_consume) ? cnt_ext : '0;
`else
      // An over-consume drains whatever is queued.
      consume_amt  = '0;
      if (i_consume_valid) begin
         consume_amt = over_consume ? count_reg : cnt_ext;
      end
`endif

      // Consume only ever retires bytes present before this edge; the fetched
      // word lands behind them, so the two updates are independent.
      count_next  = count_reg + (fetch_accept ? CW'(4) : CW'(0)) - consume_amt;
      rd_ptr_next = rd_ptr_reg + consume_amt[AW-1:0];
      wr_ptr_next = fetch_accept ? (wr_ptr_reg + AW'(4)) : wr_ptr_reg;

      if (i_flush) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage write: four consecutive bytes starting at the write pointer.
   always_ff @(posedge i_clk) begin
      if (fetch_accept && !i_flush) begin
         for (int j = 0; j < 4; j++) begin
            mem[wr_ptr_reg + AW'(j)] <= i_fetch_data[8*j +: 8];
         end
      end
   end

   // Window read is combinational from registered pointers, so a newly written
   // word only shows up after the edge that updates count_reg.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_window
         assign o_instruction[gi] = (CW'(gi) < count_reg) ?
                                    mem[rd_ptr_reg + AW'(gi)] : 8'h00;
      end
   endgenerate

`ifdef PREFETCH_QUEUE_CHECK_EN
   logic fetch_reject;
   logic error_reg;

   // A flush cancels the same-cycle fetch and consume, so neither can violate.
   assign fetch_reject = i_fetch_valid && !o_fetch_ready;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         error_reg <= 1'b0;
      end else if (!i_flush && (over_consume || fetch_reject)) begin
         error_reg <= 1'b1;
      end
   end

   assign o_error = error_reg;
`else
   assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
//
// Self-checking bench for prefetch_queue (DEPTH=16). A byte queue model runs
// alongside every transaction; a table of hand-computed vectors, a few
// multi-cycle sequences (over-consume, wrap-around, async reset) and a
// randomized run are all compared against it.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                 clk;
   logic                 reset_n;
   logic                 fetch_valid;
   logic [31:0]          fetch_data;
   logic                 fetch_ready;
   logic [0:3][7:0]      instruction;
   logic [CW-1:0]        bytes_available;
   logic                 consume_valid;
   logic [2:0]           consume_count;
   logic                 flush;
   logic                 error;

   prefetch_queue #(.DEPTH(DEPTH)) dut (
      .i_clk             (clk),
      .i_reset_n         (reset_n),
      .i_fetch_valid     (fetch_valid),
      .i_fetch_data      (fetch_data),
      .o_fetch_ready     (fetch_ready),
      .o_instruction     (instruction),
      .o_bytes_available (bytes_available),
      .i_consume_valid   (consume_valid),
      .i_consume_count   (consume_count),
      .i_flush           (flush),
      .o_error           (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Reference model: the queued bytes, oldest first, plus the sticky flag.
   logic [7:0] model_q[$];
   bit         model_err = 1'b0;

   typedef struct {
      bit          fv;
      logic [31:0] data;
      bit          cv;
      logic [2:0]  cc;
      bit          fl;
      int          avail;
      bit          ready;
      logic [31:0] win;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w = {w[23:0], (k < model_q.size()) ? model_q[k] : 8'h00};
      end
      return w;
   endfunction

   function automatic bit model_ready();
      return model_q.size() <= DEPTH - 4;
   endfunction

   task automatic model_step(input bit fv, input logic [31:0] data, input bit cv,
                             input logic [2:0] cc, input bit fl);
      bit rdy;
      rdy = model_ready();
      if (fl) begin
         model_q.delete();
      end else begin
         if (cv && cc != 0) begin
            if (int'(cc) <= model_q.size()) begin
               for (int i = 0; i < int'(cc); i++) void'(model_q.pop_front());
            end else begin
`ifdef PREFETCH_QUEUE_CHECK_EN
               model_err = 1'b1;
`else
               model_q.delete();
`endif
            end
         end
         if (fv) begin
            if (rdy) begin
               for (int i = 0; i < 4; i++) model_q.push_back(data[8*i +: 8]);
            end else begin
`ifdef PREFETCH_QUEUE_CHECK_EN
               model_err = 1'b1;
`endif
            end
         end
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".avail"}, 32'(bytes_available), 32'(model_q.size()));
      check({tag, ".ready"}, 32'(fetch_ready), 32'(model_ready()));
      check({tag, ".window"}, instruction, model_window());
      check({tag, ".error"}, 32'(error), 32'(model_err));
   endtask

   // One clocked transaction: drive, advance model, clock, compare at edge+1.
   task automatic apply(input bit fv, input logic [31:0] data, input bit cv,
                        input logic [2:0] cc, input bit fl, input string tag);
      fetch_valid   = fv;
      fetch_data    = data;
      consume_valid = cv;
      consume_count = cc;
      flush         = fl;
      model_step(fv, data, cv, cc, fl);
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d %s: fv=%0b data=%h cv=%0b cc=%0d fl=%0b -> avail=%0d ready=%0b win=%h err=%0b",
               txn, tag, fv, data, cv, cc, fl, bytes_available, fetch_ready, instruction, error);
      compare_model(tag);
      fetch_valid   = 1'b0;
      consume_valid = 1'b0;
      consume_count = 3'd0;
      flush         = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;

      reset_n       = 1'b0;
      fetch_valid   = 1'b0;
      fetch_data    = '0;
      consume_valid = 1'b0;
      consume_count = 3'd0;
      flush         = 1'b0;

      // Reset values are visible before any clock edge.
      #2;
      check("reset.ready", 32'(fetch_ready), 32'd1);
      check("reset.avail", 32'(bytes_available), 32'd0);
      check("reset.window", instruction, 32'h0);
      check("reset.error", 32'(error), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("post_reset.avail", 32'(bytes_available), 32'd0);
      check("post_reset.ready", 32'(fetch_ready), 32'd1);

      //            fv  data          cv cc fl  avail ready window
      tbl[0]  = '{1, 32'h44332211, 0, 0, 0,   4, 1, 32'h11223344};
      tbl[1]  = '{1, 32'h88776655, 0, 0, 0,   8, 1, 32'h11223344};
      tbl[2]  = '{1, 32'hCCBBAA99, 0, 0, 0,  12, 1, 32'h11223344};
      tbl[3]  = '{1, 32'h00FFEEDD, 0, 0, 0,  16, 0, 32'h11223344};
      tbl[4]  = '{0, 32'h0,        1, 3, 0,  13, 0, 32'h44556677};
      tbl[5]  = '{0, 32'h0,        1, 0, 0,  13, 0, 32'h44556677};
      tbl[6]  = '{0, 32'h0,        0, 4, 0,  13, 0, 32'h44556677};
      tbl[7]  = '{0, 32'h0,        1, 1, 0,  12, 1, 32'h55667788};
      tbl[8]  = '{1, 32'h04030201, 1, 4, 0,  12, 1, 32'h99AABBCC};
      tbl[9]  = '{0, 32'h0,        1, 4, 0,   8, 1, 32'hDDEEFF00};
      tbl[10] = '{0, 32'h0,        1, 2, 0,   6, 1, 32'hFF000102};
      tbl[11] = '{0, 32'h0,        1, 4, 0,   2, 1, 32'h03040000};
      tbl[12] = '{1, 32'h55555555, 1, 1, 1,   0, 1, 32'h00000000};
      tbl[13] = '{1, 32'hA3A2A1A0, 0, 0, 0,   4, 1, 32'hA0A1A2A3};
      tbl[14] = '{0, 32'h0,        1, 1, 0,   3, 1, 32'hA1A2A300};

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].fv, tbl[i].data, tbl[i].cv, tbl[i].cc, tbl[i].fl, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.tbl_avail", i), 32'(bytes_available), 32'(tbl[i].avail));
         check($sformatf("vec%0d.tbl_ready", i), 32'(fetch_ready), 32'(tbl[i].ready));
         check($sformatf("vec%0d.tbl_window", i), instruction, tbl[i].win);
      end

      // Over-consume with 2 bytes queued.
      apply(0, 32'h0, 1, 1, 0, "to_two");
      check("to_two.avail", 32'(bytes_available), 32'd2);
      apply(0, 32'h0, 1, 4, 0, "over_consume");
`ifdef PREFETCH_QUEUE_CHECK_EN
      check("over_consume.avail", 32'(bytes_available), 32'd2);
      check("over_consume.error", 32'(error), 32'd1);
      check("over_consume.window", instruction, 32'hA2A30000);
`else
      check("over_consume.avail", 32'(bytes_available), 32'd0);
      check("over_consume.error", 32'(error), 32'd0);
      check("over_consume.window", instruction, 32'h0);
`endif
      apply(0, 32'h0, 0, 0, 1, "flush");

      // Wrap-around: fetch 4 / consume 3 per cycle, bytes numbered by address.
      b = 8'h00;
      for (int i = 0; i < 20; i++) begin
         apply(model_ready(), {b + 8'd3, b + 8'd2, b + 8'd1, b}, 1, 3, 0, $sformatf("wrap%0d", i));
         if (model_ready()) b = b + 8'd4;
      end
      apply(0, 32'h0, 0, 0, 1, "flush2");

      // Build 9 queued bytes, then pulse reset between clock edges.
      apply(1, 32'h13121110, 0, 0, 0, "nine_a");
      apply(1, 32'h17161514, 0, 0, 0, "nine_b");
      apply(1, 32'h1B1A1918, 1, 3, 0, "nine_c");
      check("nine.avail", 32'(bytes_available), 32'd9);
      reset_n = 1'b0;
      #1;
      model_q.delete();
      model_err = 1'b0;
      check("async_reset.avail", 32'(bytes_available), 32'd0);
      check("async_reset.ready", 32'(fetch_ready), 32'd1);
      check("async_reset.window", instruction, 32'h0);
      check("async_reset.error", 32'(error), 32'd0);
      #1;
      reset_n = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 4)), $urandom_range(0, 99) < 3, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
